// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 Booth multiplier, 16x16 signed -> 32-bit product, valid/ready result side.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining Booth groups are all zero.
module booth_r4_seq_mult #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic [2:0]           booth_grp,
    output logic [2*WIDTH-1:0]   product,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int unsigned ITER = WIDTH / 2;
    localparam int unsigned CntW = $clog2(ITER);
    localparam int unsigned PW   = 2 * WIDTH;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  m_q;
    logic [WIDTH:0]    q_ext_q;
    logic [PW-1:0]     acc_q;
    logic [PW-1:0]     product_q;
    logic [CntW-1:0]   cnt_q;

    logic [PW-1:0]     m_ext;
    logic [PW-1:0]     pp;
    logic [PW-1:0]     acc_sum;
    logic              last_iter;
    logic              early_done;

    assign m_ext     = {{WIDTH{m_q[WIDTH-1]}}, m_q};
    assign last_iter = (cnt_q == CntW'(ITER - 1));

`ifdef BOOTH_EARLY_TERM_EN
    // All-zero or all-one q_ext means every remaining group decodes to 0.
    assign early_done = (q_ext_q == '0) || (q_ext_q == '1);
`else
    assign early_done = 1'b0;
`endif

    always_comb begin
        pp = '0;
        unique case (q_ext_q[2:0])
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_ext << 1;
            3'b100:         pp = -(m_ext << 1);
            3'b101, 3'b110: pp = -m_ext;
            default:        pp = '0;
        endcase
        acc_sum = acc_q + (pp << {cnt_q, 1'b0});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (early_done || last_iter) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        booth_grp = (state_q == StRun) ? q_ext_q[2:0] : 3'b000;
    end

    assign product = product_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            q_ext_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        m_q     <= multiplicand;
                        q_ext_q <= {multiplier, 1'b0};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    if (early_done) begin
                        product_q <= acc_q;
                    end else begin
                        acc_q   <= acc_sum;
                        q_ext_q <= {{2{q_ext_q[WIDTH]}}, q_ext_q[WIDTH:2]};
                        cnt_q   <= cnt_q + 1'b1;
                        if (last_iter) product_q <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
